// File: rtl/conv_result_packer.sv
// conv_result_packer: FWFT FIFO turning conv results into an AXI4-Stream with tuser/tlast framing.
// Define CONV_PACK_ROW_TLAST_EN to raise tlast at every row end instead of only at frame end.
module conv_result_packer #(
    parameter int SUM_BW     = 16,
    parameter int OUT_SIZE   = 28,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int CNT_BW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SUM_BW-1:0] i_y,
    input  logic              i_valid,
    input  logic              i_clear,
    output logic [SUM_BW-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              o_overflow,
    output logic              o_frame_done,
    output logic [FIFO_AW:0]  o_fifo_count
);
`ifdef CONV_PACK_ROW_TLAST_EN
    localparam int EW = SUM_BW + 3;
`else
    localparam int EW = SUM_BW + 2;
`endif
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [FIFO_AW:0]    cnt_q, cnt_d;
    logic [CNT_BW-1:0]   col_q, col_d, row_q, row_d;
    logic                ovf_q, ovf_d, done_q, done_d;
    logic                pop, push, col_last, row_last, sof, fend;
    logic [EW-1:0]       entry, head;
    always_comb begin
        head     = mem_q[rd_q];
        pop      = (cnt_q != '0) && m_axis_tready;
        push     = i_valid && ((cnt_q < (FIFO_AW+1)'(FIFO_DEPTH)) || pop);
        col_last = col_q == CNT_BW'(OUT_SIZE - 1);
        row_last = row_q == CNT_BW'(OUT_SIZE - 1);
        sof      = (row_q == '0) && (col_q == '0);
        fend     = row_last && col_last;
`ifdef CONV_PACK_ROW_TLAST_EN
        entry    = {sof, col_last, fend, i_y};
`else
        entry    = {sof, fend, i_y};
`endif
        rd_d     = pop ? rd_q + 1'b1 : rd_q;
        wr_d     = push ? wr_q + 1'b1 : wr_q;
        cnt_d    = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        // Counters track every input, dropped or not, so framing survives loss.
        col_d    = !i_valid ? col_q : col_last ? '0 : col_q + 1'b1;
        row_d    = !(i_valid && col_last) ? row_q : row_last ? '0 : row_q + 1'b1;
        ovf_d    = ovf_q | (i_valid && !push);
        done_d   = pop && head[SUM_BW];
    end
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            col_q  <= '0;
            row_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            col_q  <= col_d;
            row_q  <= row_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= entry;
    end
    assign m_axis_tvalid = cnt_q != '0;
    assign m_axis_tdata  = m_axis_tvalid ? head[SUM_BW-1:0] : '0;
    assign m_axis_tuser  = m_axis_tvalid && head[EW-1];
    assign m_axis_tlast  = m_axis_tvalid && head[EW-2];
    assign o_overflow    = ovf_q;
    assign o_frame_done  = done_q;
    assign o_fifo_count  = cnt_q;
endmodule
